// File: rtl/mux_lut_cam_pkg.sv
// rtl/mux_lut_cam_pkg.sv - shared types and helpers for the programmable lookup table
package mux_pkg;

   typedef enum logic {MUX_MODE_OR, MUX_MODE_PRIO} mux_mode_e;

   // Index fields stay at least one bit wide, even for a single-entry table
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_lut_cam_if.sv
// rtl/mux_lut_cam_if.sv - lookup request/response handshake bundle
interface mux_lut_cam_if #(
   parameter int KEY_LEN  = 8,
   parameter int DATA_LEN = 32,
   parameter int IDX_W    = 2
);
   logic                req_valid;
   logic                req_ready;
   logic [KEY_LEN-1:0]  req_key;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [DATA_LEN-1:0] rsp_data;
   logic                rsp_hit;
   logic [IDX_W-1:0]    rsp_idx;
   logic                rsp_multi;

   modport master (
      output req_valid, req_key, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi
   );

   modport slave (
      input  req_valid, req_key, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_hit, rsp_idx, rsp_multi
   );
endinterface

// File: rtl/mux_lut_cam_match.sv
// rtl/mux_lut_cam_match.sv - combinational key compare, priority encode and data select
module mux_lut_match
   import mux_pkg::*;
#(
   parameter int        NR_KEY   = 4,
   parameter int        KEY_LEN  = 8,
   parameter int        DATA_LEN = 32,
   parameter mux_mode_e MODE     = MUX_MODE_PRIO,
   parameter int        IDX_W    = clog2_min1(NR_KEY)
) (
   input  logic [KEY_LEN-1:0]                req_key,
   input  logic [NR_KEY-1:0][KEY_LEN-1:0]    keys,
   input  logic [NR_KEY-1:0][DATA_LEN-1:0]   data,
   input  logic [NR_KEY-1:0]                 vld,
   output logic [NR_KEY-1:0]                 match,
   output logic [IDX_W-1:0]                  idx,
   output logic                              multi,
   output logic [DATA_LEN-1:0]               sel_data
);

   always_comb begin
      for (int i = 0; i < NR_KEY; i++) begin
         match[i] = vld[i] && (keys[i] == req_key);
      end
   end

   // Descending scan so the lowest matching entry is the last one assigned
   always_comb begin
      logic found;
      idx      = '0;
      multi    = 1'b0;
      sel_data = '0;
      found    = 1'b0;
      for (int i = NR_KEY - 1; i >= 0; i--) begin
         if (match[i]) begin
            idx = IDX_W'(i);
            if (MODE == MUX_MODE_PRIO) begin
               sel_data = data[i];
            end else begin
               sel_data = sel_data | data[i];
            end
            if (found) begin
               multi = 1'b1;
            end
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_lut_cam.sv
// rtl/mux_lut_cam.sv - programmable key->data table with one-stage registered lookup
module mux_lut_cam
   import mux_pkg::*;
#(
   parameter int        NR_KEY      = 4,
   parameter int        KEY_LEN     = 8,
   parameter int        DATA_LEN    = 32,
   parameter int        HAS_DEFAULT = 0,
   parameter mux_mode_e MODE        = MUX_MODE_PRIO,
   parameter int        CNT_LEN     = 16,
   localparam int       IDX_W       = clog2_min1(NR_KEY)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [IDX_W-1:0]     wr_idx,
   input  logic [KEY_LEN-1:0]   wr_key,
   input  logic [DATA_LEN-1:0]  wr_data,
   input  logic                 wr_vld,
   input  logic                 flush,
   input  logic [DATA_LEN-1:0]  default_out,
   mux_lut_cam_if.slave         lk,
   output logic [CNT_LEN-1:0]   hit_cnt,
   output logic [CNT_LEN-1:0]   miss_cnt
);

   logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q;
   logic [NR_KEY-1:0][DATA_LEN-1:0] data_q;
   logic [NR_KEY-1:0]               vld_q;

   logic [NR_KEY-1:0]   match;
   logic [IDX_W-1:0]    m_idx;
   logic                m_multi;
   logic [DATA_LEN-1:0] m_data;
   logic                m_hit;
   logic                accept;
   logic                wr_ok;

   assign wr_ok        = wr_en && !flush && (int'(wr_idx) < NR_KEY);
   assign lk.req_ready = !lk.rsp_valid || lk.rsp_ready;
   assign accept       = lk.req_valid && lk.req_ready;
   assign m_hit        = |match;

   mux_lut_match #(
      .NR_KEY   (NR_KEY),
      .KEY_LEN  (KEY_LEN),
      .DATA_LEN (DATA_LEN),
      .MODE     (MODE),
      .IDX_W    (IDX_W)
   ) u_match (
      .req_key  (lk.req_key),
      .keys     (key_q),
      .data     (data_q),
      .vld      (vld_q),
      .match    (match),
      .idx      (m_idx),
      .multi    (m_multi),
      .sel_data (m_data)
   );

   // Key/data payload carries no reset; the valid bits alone gate matching
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         key_q[wr_idx]  <= wr_key;
         data_q[wr_idx] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
      end else if (flush) begin
         vld_q <= '0;
      end else if (wr_ok) begin
         vld_q[wr_idx] <= wr_vld;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lk.rsp_valid <= 1'b0;
         lk.rsp_data  <= '0;
         lk.rsp_hit   <= 1'b0;
         lk.rsp_idx   <= '0;
         lk.rsp_multi <= 1'b0;
         hit_cnt      <= '0;
         miss_cnt     <= '0;
      end else if (accept) begin
         lk.rsp_valid <= 1'b1;
         lk.rsp_hit   <= m_hit;
         lk.rsp_idx   <= m_idx;
         lk.rsp_multi <= m_multi;
         if (m_hit) begin
            lk.rsp_data <= m_data;
            if (hit_cnt != '1) begin
               hit_cnt <= hit_cnt + CNT_LEN'(1);
            end
         end else begin
            lk.rsp_data <= (HAS_DEFAULT != 0) ? default_out : '0;
            if (miss_cnt != '1) begin
               miss_cnt <= miss_cnt + CNT_LEN'(1);
            end
         end
      end else if (lk.rsp_ready) begin
         lk.rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_lut_cam.sv
// tb/tb_mux_lut_cam.sv - scoreboard bench for the programmable lookup table
module tb_mux_lut_cam;
   import mux_pkg::*;

   localparam int NK = 5;
   localparam int KW = 8;
   localparam int DW = 32;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [IW-1:0] wr_idx = '0;
   logic [KW-1:0] wr_key = '0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_vld = 1'b0;
   logic          flush = 1'b0;
   logic [DW-1:0] default_out = '0;
   logic          req_valid = 1'b0;
   logic [KW-1:0] req_key = '0;
   logic          rsp_ready = 1'b1;
   logic [15:0]   hit_cnt_a, miss_cnt_a;
   logic [1:0]    hit_cnt_b, miss_cnt_b;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   always #5 clk = ~clk;

   mux_lut_cam_if #(.KEY_LEN(KW), .DATA_LEN(DW), .IDX_W(IW)) if_a ();
   mux_lut_cam_if #(.KEY_LEN(KW), .DATA_LEN(DW), .IDX_W(IW)) if_b ();

   assign if_a.req_valid = req_valid;
   assign if_a.req_key   = req_key;
   assign if_a.rsp_ready = rsp_ready;
   assign if_b.req_valid = req_valid;
   assign if_b.req_key   = req_key;
   assign if_b.rsp_ready = rsp_ready;

   mux_lut_cam #(.NR_KEY(NK), .KEY_LEN(KW), .DATA_LEN(DW), .HAS_DEFAULT(1),
                 .MODE(MUX_MODE_PRIO), .CNT_LEN(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
      .wr_data(wr_data), .wr_vld(wr_vld), .flush(flush), .default_out(default_out),
      .lk(if_a.slave), .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a));

   mux_lut_cam #(.NR_KEY(NK), .KEY_LEN(KW), .DATA_LEN(DW), .HAS_DEFAULT(0),
                 .MODE(MUX_MODE_OR), .CNT_LEN(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key),
      .wr_data(wr_data), .wr_vld(wr_vld), .flush(flush), .default_out(default_out),
      .lk(if_b.slave), .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b));

   typedef struct {
      logic [DW-1:0] da;
      logic [DW-1:0] db;
      logic          hit;
      logic [IW-1:0] idx;
      logic          multi;
   } exp_t;

   exp_t          sb[$];
   logic [KW-1:0] mkey [NK];
   logic [DW-1:0] mdata[NK];
   logic [NK-1:0] mvld = '0;
   int hc_a = 0, mc_a = 0, hc_b = 0, mc_b = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: evaluated half a cycle before each rising edge
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         exp_t e;
         bit   acc;
         acc = req_valid && (sb.size() == 0 || rsp_ready);
         check("rsp_valid_a", 64'(if_a.rsp_valid), 64'(sb.size() != 0));
         check("rsp_valid_b", 64'(if_b.rsp_valid), 64'(sb.size() != 0));
         check("req_ready_a", 64'(if_a.req_ready), 64'(sb.size() == 0 || rsp_ready));
         check("req_ready_b", 64'(if_b.req_ready), 64'(sb.size() == 0 || rsp_ready));
         check("hit_cnt_a",  64'(hit_cnt_a),  64'(hc_a));
         check("miss_cnt_a", 64'(miss_cnt_a), 64'(mc_a));
         check("hit_cnt_b",  64'(hit_cnt_b),  64'(hc_b));
         check("miss_cnt_b", 64'(miss_cnt_b), 64'(mc_b));
         if (sb.size() != 0) begin
            e = sb[0];
            check("data_a",  64'(if_a.rsp_data),  64'(e.da));
            check("data_b",  64'(if_b.rsp_data),  64'(e.db));
            check("hit_a",   64'(if_a.rsp_hit),   64'(e.hit));
            check("hit_b",   64'(if_b.rsp_hit),   64'(e.hit));
            check("idx_a",   64'(if_a.rsp_idx),   64'(e.idx));
            check("multi_b", 64'(if_b.rsp_multi), 64'(e.multi));
            if (rsp_ready) void'(sb.pop_front());
         end
         if (acc) begin
            logic [DW-1:0] dor;
            e.hit = 0; e.idx = '0; e.multi = 0; e.da = '0; dor = '0;
            for (int i = 0; i < NK; i++) begin
               if (mvld[i] && mkey[i] == req_key) begin
                  if (!e.hit) begin
                     e.idx = IW'(i);
                     e.da  = mdata[i];
                  end else begin
                     e.multi = 1;
                  end
                  e.hit = 1;
                  dor   = dor | mdata[i];
               end
            end
            e.db = e.hit ? dor : '0;
            if (!e.hit) e.da = default_out;
            if (e.hit) begin
               hc_a++;
               if (hc_b < 3) hc_b++;
            end else begin
               mc_a++;
               if (mc_b < 3) mc_b++;
            end
            sb.push_back(e);
         end
         if (flush) begin
            mvld = '0;
         end else if (wr_en && int'(wr_idx) < NK) begin
            mkey[wr_idx]  = wr_key;
            mdata[wr_idx] = wr_data;
            mvld[wr_idx]  = wr_vld;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 0; flush = 0; req_valid = 0;
   endtask

   task automatic write(input int idx, input logic [KW-1:0] k, input logic [DW-1:0] d, input bit v);
      wr_en = 1; wr_idx = IW'(idx); wr_key = k; wr_data = d; wr_vld = v;
   endtask

   task automatic lookup(input logic [KW-1:0] k);
      req_valid = 1; req_key = k;
      tick();
      idle();
   endtask

   initial begin
      repeat (3) tick();
      check("rst_valid_a", 64'(if_a.rsp_valid), 64'd0);
      check("rst_data_a",  64'(if_a.rsp_data),  64'd0);
      check("rst_ready_b", 64'(if_b.req_ready), 64'd1);
      check("rst_cnt_a",   64'({hit_cnt_a, miss_cnt_a}), 64'd0);
      rst_n  = 1;
      mon_en = 1;
      tick();

      lookup(8'h00);
      tick();

      write(1, 8'h12, 32'hAAAA_0000, 1); tick();
      write(3, 8'h12, 32'h0000_BBBB, 1); tick();
      idle();
      lookup(8'h12);
      tick();

      default_out = 32'h0000_DEAD;
      lookup(8'h99);
      tick();

      write(0, 8'h05, 32'h5555_0005, 1);
      req_valid = 1; req_key = 8'h05;
      tick();
      idle();
      lookup(8'h05);
      tick();

      rsp_ready = 0; req_valid = 1; req_key = 8'h12;
      tick();
      req_key = 8'h05; default_out = 32'h0000_BEEF;
      repeat (3) tick();
      rsp_ready = 1;
      tick();
      idle();
      tick();

      write(6, 8'h77, 32'h7777_7777, 1); tick();
      write(3, 8'h12, 32'h0000_BBBB, 0); tick();
      idle();
      lookup(8'h77);
      lookup(8'h12);
      tick();

      write(3, 8'h12, 32'h0000_CCCC, 1);
      req_valid = 1; req_key = 8'h12;
      tick();
      wr_en = 0;
      for (int c = 0; c < 8; c++) begin
         if (c == 3) begin
            flush = 1;
            write(2, 8'h12, 32'h2222_2222, 1);
         end else begin
            flush = 0; wr_en = 0;
         end
         tick();
      end
      idle();
      lookup(8'h05);
      tick();

      for (int c = 0; c < 60; c++) begin
         idle();
         if ($urandom_range(0, 3) == 0)
            write($urandom_range(0, 7), 8'(8'h10 + $urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 15) == 0) flush = 1;
         req_valid = 1'($urandom_range(0, 1));
         req_key   = 8'(8'h10 + $urandom_range(0, 3));
         rsp_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) default_out = $urandom;
         tick();
      end
      idle();
      rsp_ready = 1;
      repeat (3) tick();
      check("drain", 64'(sb.size()), 64'd0);

      rsp_ready = 0; req_valid = 1; req_key = 8'h11;
      tick();
      req_valid = 0;
      tick();
      mon_en = 0;
      rst_n  = 0;
      #1;
      check("async_drop_a", 64'(if_a.rsp_valid), 64'd0);
      check("async_drop_b", 64'(if_b.rsp_valid), 64'd0);
      check("async_cnt_a",  64'({hit_cnt_a, miss_cnt_a}), 64'd0);
      sb.delete();
      mvld = '0; hc_a = 0; mc_a = 0; hc_b = 0; mc_b = 0;
      tick();
      rst_n = 1; rsp_ready = 1;
      tick();
      check("post_rst_ready", 64'(if_a.req_ready), 64'd1);
      mon_en = 1;
      lookup(8'h12);
      repeat (2) tick();
      check("final_drain", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
